round_key_adder: RTL

ROUND_KEY_ADDER -- requirements
Module: round_key_adder

---
 rtl/round_key_adder.sv | 128 ++++++++++++
 1 files changed

// File: rtl/round_key_adder.sv
// Round-key XOR engine: a key bank plus a slice-serial XOR of one cipher state.
// A key snapshot taken at accept keeps in-flight results independent of later key writes.
module round_key_adder #(
   parameter int BLOCK_W = 128,
   parameter int WORD_W  = 32,
   parameter int NKEYS   = 11,
   parameter int IDX_W   = (NKEYS > 1) ? $clog2(NKEYS) : 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               key_wr_en,
   input  logic [IDX_W-1:0]   key_wr_idx,
   input  logic [BLOCK_W-1:0] key_wr_data,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [BLOCK_W-1:0] in_data,
   input  logic [IDX_W-1:0]   in_round,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [BLOCK_W-1:0] out_data,
   output logic [IDX_W-1:0]   out_round,
   output logic               err
);

   localparam int NS    = BLOCK_W / WORD_W;
   localparam int CNT_W = (NS > 1) ? $clog2(NS) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(NS - 1);
   localparam logic [IDX_W:0]   NKV  = (IDX_W + 1)'(NKEYS);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t             st;
   state_t             nxt;
   logic [BLOCK_W-1:0] keys [NKEYS];
   logic [BLOCK_W-1:0] work_q;
   logic [BLOCK_W-1:0] key_q;
   logic [BLOCK_W-1:0] mix;
   logic [IDX_W-1:0]   rnd_q;
   logic [CNT_W-1:0]   cnt;
   logic               wr_ok;
   logic               rd_ok;
   logic               accept;
   logic               last;

   assign wr_ok = {1'b0, key_wr_idx} < NKV;
   assign rd_ok = {1'b0, in_round} < NKV;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         st <= IDLE;
      end else begin
         st <= nxt;
      end
   end

   always_comb begin
      nxt       = st;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      accept    = 1'b0;
      last      = 1'b0;
      unique case (st)
         IDLE: begin
            in_ready = 1'b1;
            accept   = in_valid;
            if (in_valid) nxt = BUSY;
         end
         BUSY: begin
            last = (cnt == LAST);
            if (last) nxt = DONE;
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) nxt = IDLE;
         end
         default: nxt = IDLE;
      endcase
   end

   // only the slice selected by cnt is combined this cycle
   always_comb begin
      mix = work_q;
      for (int k = 0; k < NS; k++) begin
         if (cnt == CNT_W'(k)) begin
            mix[k*WORD_W +: WORD_W] = work_q[k*WORD_W +: WORD_W]
                                    ^ key_q[k*WORD_W +: WORD_W];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NKEYS; i++) keys[i] <= '0;
      end else if (key_wr_en && wr_ok) begin
         keys[key_wr_idx] <= key_wr_data;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         work_q    <= '0;
         key_q     <= '0;
         rnd_q     <= '0;
         cnt       <= '0;
         out_data  <= '0;
         out_round <= '0;
         err       <= 1'b0;
      end else begin
         if (key_wr_en && !wr_ok) err <= 1'b1;
         if (accept) begin
            work_q <= in_data;
            rnd_q  <= in_round;
            key_q  <= rd_ok ? keys[in_round] : '0;
            cnt    <= '0;
            if (!rd_ok) err <= 1'b1;
         end
         if (st == BUSY) begin
            work_q <= mix;
            cnt    <= cnt + 1'b1;
            if (last) begin
               out_data  <= mix;
               out_round <= rnd_q;
            end
         end
      end
   end

endmodule
